pulse_burst_scheduler: RTL
==========================

# pulse_burst_scheduler

Shares one pulse output between `N_REQ` requesters. Each requester asks for a burst of `K` single-cycle pulses with a programmable low gap between them. A round-robin arbiter picks the next requester, and a burst sequencer FSM runs the granted burst to completion. The block sits between the user-control logic (switch/command decode) and the LED/strobe pulse output, and replaces per-source pulse generators.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `CNT_W`, 8, width of pulse-count field
- `GAP_W`, 8, width of low-gap field

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `req`  in  N_REQ  level request per requester; held until `done` or abort
- `req_count`  in  N_REQ*CNT_W  pulses requested; requester i at bits [i*CNT_W +: CNT_W]
- `req_gap`  in  N_REQ*GAP_W  low cycles between pulses; same packing as `req_count`
- `gnt`  out  N_REQ  one-hot grant, zero when idle
- `done`  out  N_REQ  one-cycle completion strobe to the owning requester
- `owner`  out  3  index of the current grant holder, 0 when idle
- `P`  out  1  shared pulse output
- `L`  out  1  busy level, high while a burst is active

## Operation
- FSM states are IDLE, LOAD, HIGH, LOW and DONE.
- **IDLE**
  - If any `req` bit is high, the round-robin winner is chosen and the FSM goes to LOAD.
  - The search starts at pointer `rr_ptr` and wraps modulo `N_REQ`.
- **LOAD**
  - `gnt[w]`=1 and `owner`=w.
  - Latches `cnt_r`=`req_count[w]` and `gap_r`=max(`req_gap[w]`,1).
  - `rr_ptr` becomes (w+1) mod `N_REQ`.
  - If `cnt_r`==0, go to DONE (no pulses). Otherwise go to HIGH.
- **HIGH**
  - `P`=1 for exactly one cycle.
  - `cnt_r` is decremented and the gap counter is loaded with `gap_r`.
  - Go to LOW.
- **LOW**
  - `P`=0 and the gap counter decrements.
  - When it reaches 0: go to HIGH if `cnt_r`!=0, otherwise go to DONE.
- **DONE**
  - `done[w]`=1 for one cycle.
  - `gnt`=0, `L`=0, then go to IDLE.
- `L`=1 in LOAD, HIGH and LOW; `L`=0 in IDLE and DONE.
- Abort: if `req[w]` drops in LOAD, HIGH or LOW, the next state is IDLE.
  - `P` and `gnt` are 0 from the next cycle.
  - No `done` is issued.
  - `rr_ptr` has already advanced.
- Request and config inputs of non-owners are ignored while busy. Owner config changes after LOAD are ignored.
- A requester that keeps `req` high after `done` re-enters arbitration behind the others (pointer already advanced).

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `gnt`=0, `done`=0, `owner`=0, `P`=0, `L`=0. Reset overrides every state, mid-burst included, at the next edge.
- Latency:
  - `req` sampled at edge t in IDLE gives `gnt` in cycle t+1 (LOAD).
  - The first `P` is in cycle t+2.
- Pulse period is `gap_r`+1 cycles. Gap 0 is treated as 1, so the minimum period is 2 and consecutive pulses are always separated.
- Burst of K pulses with gap G (K≥1, G≥1):
  - Pulse n is high in cycle t+2+n*(G+1), for n=0..K-1.
  - `done` is in cycle t+2+K*(G+1).
  - The next grant is possible 2 cycles after `done` (IDLE, then LOAD).
- Simultaneous `req` edges are resolved by `rr_ptr` order only. There is no fixed priority.
- All outputs are registered or decoded from state registers. There are no combinational paths from `req` to `P`.

## Structure
- Shared header `pulse_sched_defs.vh`: state encodings (IDLE..DONE) and index-width localparam.
- Sub-module `rr_arbiter`:
  - Inputs are `req` and `rr_ptr`.
  - Outputs are a one-hot winner and its index (combinational).
  - The FSM, counters and pointer live in the top.

## Test plan
- Reset mid-burst: start a burst, assert `reset` during LOW → next cycle `P`=0, `L`=0, `gnt`=0, no `done`; a new request grants requester 0 first.
- Single request: req[1], count=3, gap=2 → `gnt`=0010 at t+1; `P` high at t+2, t+5, t+8; `done[1]` at t+11; `L` high t+1..t+10.
- Round robin: all four `req` high together, count=1, gap=1 → grants in order 0,1,2,3,0; each `done` strobes exactly once per grant.
- Zero/edge config: count=0 → LOAD then DONE, no `P`. Gap=0 with count=2 → `P` at t+2 and t+4. Count=255, gap=255 → 255 pulses, no wrap.
- Abort: drop req[2] after its second pulse → `gnt`=0 next cycle, no further `P`, no `done[2]`; a pending req[3] is granted 2 cycles later.

Source files
------------

// File: rtl/pulse_burst_scheduler_pkg.sv
// Shared constants for the pulse burst scheduler: FSM encodings, index width
// and the round-robin pointer wrap helper.
package pulse_burst_scheduler_pkg;

  localparam int IDX_W = 3;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_HIGH = 3'd2;
  localparam logic [2:0] S_LOW  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Next pointer position after index idx, wrapping modulo n.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/pulse_burst_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after rr_ptr,
// wrapping modulo N_REQ, wins.
module pulse_burst_scheduler_rr_arbiter
  import pulse_burst_scheduler_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_valid
);

  // Distance from the pointer decides priority, so no requester is favoured.
  always_comb begin
    int best_d;
    int d;
    win_idx   = '0;
    win_valid = 1'b0;
    best_d    = N_REQ;
    d         = 0;
    for (int j = 0; j < N_REQ; j++) begin
      d = j - int'(rr_ptr);
      if (d < 0) d = d + N_REQ;
      if (req[j] && (d < best_d)) begin
        best_d    = d;
        win_idx   = IDX_W'(j);
        win_valid = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign win_onehot[gi] = win_valid && (win_idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/pulse_burst_scheduler.sv
// Shares one pulse output between N_REQ requesters: round-robin grant, then a
// sequencer emits the owner's burst of single-cycle pulses with a low gap.
module pulse_burst_scheduler
  import pulse_burst_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] req_count,
  input  logic [N_REQ*GAP_W-1:0] req_gap,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [IDX_W-1:0]       owner,
  output logic                   P,
  output logic                   L
);

  logic [2:0]       state_reg;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] owner_reg;
  logic [N_REQ-1:0] onehot_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [GAP_W-1:0] gap_reg;
  logic [GAP_W-1:0] gap_cnt_reg;

  logic [N_REQ-1:0] win_onehot;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;

  logic [CNT_W-1:0] count_arr [N_REQ];
  logic [GAP_W-1:0] gap_arr   [N_REQ];
  logic [CNT_W-1:0] sel_count;
  logic [GAP_W-1:0] sel_gap;
  logic             owner_req;
  logic             busy;

  pulse_burst_scheduler_rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr_reg),
    .win_onehot(win_onehot),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign count_arr[gi] = req_count[gi*CNT_W +: CNT_W];
      assign gap_arr[gi]   = req_gap[gi*GAP_W +: GAP_W];
    end
  endgenerate

  always_comb begin
    sel_count = '0;
    sel_gap   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (onehot_reg[i]) begin
        sel_count = count_arr[i];
        sel_gap   = gap_arr[i];
      end
    end
  end

  // Only the owner's request matters once granted; dropping it aborts.
  assign owner_req = |(req & onehot_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      rr_ptr_reg  <= '0;
      owner_reg   <= '0;
      onehot_reg  <= '0;
      cnt_reg     <= '0;
      gap_reg     <= '0;
      gap_cnt_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (win_valid) begin
            owner_reg  <= win_idx;
            onehot_reg <= win_onehot;
            rr_ptr_reg <= wrap_inc(win_idx, N_REQ);
            state_reg  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!owner_req) begin
            state_reg <= S_IDLE;
          end else begin
            cnt_reg   <= sel_count;
            gap_reg   <= (sel_gap == '0) ? GAP_W'(1) : sel_gap;
            state_reg <= (sel_count == '0) ? S_DONE : S_HIGH;
          end
        end
        S_HIGH: begin
          if (!owner_req) begin
            state_reg <= S_IDLE;
          end else begin
            cnt_reg     <= cnt_reg - CNT_W'(1);
            gap_cnt_reg <= gap_reg;
            state_reg   <= S_LOW;
          end
        end
        S_LOW: begin
          if (!owner_req) begin
            state_reg <= S_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
            if (gap_cnt_reg == GAP_W'(1))
              state_reg <= (cnt_reg != '0) ? S_HIGH : S_DONE;
          end
        end
        S_DONE: state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy  = (state_reg == S_LOAD) || (state_reg == S_HIGH) || (state_reg == S_LOW);
  assign L     = busy;
  assign P     = (state_reg == S_HIGH);
  assign gnt   = busy ? onehot_reg : '0;
  assign done  = (state_reg == S_DONE) ? onehot_reg : '0;
  assign owner = (state_reg != S_IDLE) ? owner_reg : '0;

endmodule
